// File: rtl/sip_pkg.sv
// ---------------------------------------------------------------------------
// sip_pkg
// Shared definitions for the synaptic input processor:
//   - array sizes, weight/potential widths, firing threshold and leak
//   - FSM state encoding (IDLE / LOAD / ACCUM / FIRE)
//   - weight-table initialiser (w[i] = i)
// ---------------------------------------------------------------------------
package sip_pkg;

  localparam int N_SYN     = 16;               // presynaptic inputs
  localparam int SEL_WIDTH = $clog2(N_SYN);    // synapse index width
  localparam int W_WIDTH   = 4;                // unsigned synaptic weight
  localparam int POT_WIDTH = 12;               // unsigned membrane potential
  localparam int ACC_WIDTH = 8;                // holds sum of all 16 weights (max 120)
  localparam int THRESHOLD = 64;               // firing threshold
  localparam int LEAK      = 1;                // decrement applied every window

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACCUM,
    FIRE
  } state_t;

  typedef logic [N_SYN-1:0][W_WIDTH-1:0] weight_table_t;

  // Ramp table: synapse i carries weight i.
  function automatic weight_table_t init_weights();
    weight_table_t w;
    for (int i = 0; i < N_SYN; i++) begin
      w[i] = W_WIDTH'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/synaptic_input_processor_lif_neuron.sv
// ---------------------------------------------------------------------------
// lif_neuron
// Leaky integrate-and-fire membrane. On each update strobe the potential
// becomes V + exc_acc - inh_acc - LEAK, clamped to [0, 2^POT_WIDTH-1];
// when that value reaches THRESHOLD the neuron fires and V resets to 0.
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high; clears V
//   update   in   one-cycle strobe, high during the FIRE cycle
//   exc_acc  in   excitatory weight sum for the window
//   inh_acc  in   inhibitory weight sum for the window
//   fire     out  combinational; high when this update crosses threshold
// ---------------------------------------------------------------------------
module lif_neuron
  import sip_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 update,
  input  logic [ACC_WIDTH-1:0] exc_acc,
  input  logic [ACC_WIDTH-1:0] inh_acc,
  output logic                 fire
);

  // Two spare bits: one for the sign, one for headroom above 2^POT_WIDTH-1.
  localparam int SUM_WIDTH = POT_WIDTH + 2;

  localparam logic signed [SUM_WIDTH-1:0] LEAK_S  = SUM_WIDTH'(LEAK);
  localparam logic signed [SUM_WIDTH-1:0] V_MAX_S = SUM_WIDTH'((1 << POT_WIDTH) - 1);

  logic [POT_WIDTH-1:0]        v_q;
  logic signed [SUM_WIDTH-1:0] v_sum;
  logic [POT_WIDTH-1:0]        v_clamped;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    v_sum     = signed'({2'b00, v_q})
              + signed'(SUM_WIDTH'(exc_acc))
              - signed'(SUM_WIDTH'(inh_acc))
              - LEAK_S;
    v_clamped = v_sum[POT_WIDTH-1:0];
    if (v_sum < 0) begin
      v_clamped = '0;
    end else if (v_sum > V_MAX_S) begin
      v_clamped = '1;
    end
    fire = update && (v_clamped >= POT_WIDTH'(THRESHOLD));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q <= '0;
    end else if (update) begin
      v_q <= fire ? '0 : v_clamped;
    end
  end

endmodule

// File: rtl/synaptic_input_processor.sv
// ---------------------------------------------------------------------------
// synaptic_input_processor
// Time-multiplexed synaptic front end for one LIF neuron with 16 inputs.
// Each 18-cycle window: LOAD captures the spike vector and E/I mask, ACCUM
// walks synapses 0..15 adding stored weights into excitatory/inhibitory
// sums, FIRE updates the membrane and pulses the flush strobes that pace
// the upstream fetch logic.
//
// Ports
//   clock              in   system clock, rising edge
//   reset              in   asynchronous, active-high
//   write              in   run enable; a window starts only while high
//   parallel_spike_in  in   presynaptic spikes, bit i = synapse i
//   parallel_Ein       in   synapse type, 1 = excitatory, 0 = inhibitory
//   flush_weight       out  high during the FIRE cycle
//   flush_Ein          out  high during the FIRE cycle
//   flush_spike        out  high during the FIRE cycle
//   spike              out  one-cycle output spike, the cycle after FIRE
//   select             out  index of synapse being processed
//   toggle             out  inverts once per completed window
// ---------------------------------------------------------------------------
module synaptic_input_processor
  import sip_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write,
  input  logic [N_SYN-1:0]     parallel_spike_in,
  input  logic [N_SYN-1:0]     parallel_Ein,
  output logic                 flush_weight,
  output logic                 flush_Ein,
  output logic                 flush_spike,
  output logic                 spike,
  output logic [SEL_WIDTH-1:0] select,
  output logic                 toggle
);

  // NOTE: the weight table has no write path, so it is a constant rather
  // than a reset register array; it always equals its reset image.
  localparam weight_table_t WEIGHTS = init_weights();

  state_t               state_q;
  logic [N_SYN-1:0]     spk_q;
  logic [N_SYN-1:0]     ein_q;
  logic [ACC_WIDTH-1:0] exc_acc;
  logic [ACC_WIDTH-1:0] inh_acc;
  logic                 flush_q;
  logic                 fire;

  lif_neuron u_lif (
    .clock   (clock),
    .reset   (reset),
    .update  (state_q == FIRE),
    .exc_acc (exc_acc),
    .inh_acc (inh_acc),
    .fire    (fire)
  );

  // The three strobes are one request seen by three upstream fetchers.
  assign flush_weight = flush_q;
  assign flush_Ein    = flush_q;
  assign flush_spike  = flush_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      select  <= '0;
      spk_q   <= '0;
      ein_q   <= '0;
      exc_acc <= '0;
      inh_acc <= '0;
      flush_q <= 1'b0;
      spike   <= 1'b0;
      toggle  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      flush_q <= 1'b0;
      spike   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          select <= '0;
          if (write) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          spk_q   <= parallel_spike_in;
          ein_q   <= parallel_Ein;
          exc_acc <= '0;
          inh_acc <= '0;
          select  <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          if (spk_q[select]) begin
            if (ein_q[select]) begin
              exc_acc <= exc_acc + ACC_WIDTH'(WEIGHTS[select]);
            end else begin
              inh_acc <= inh_acc + ACC_WIDTH'(WEIGHTS[select]);
            end
          end
          // Wraps to 0 after the last synapse.
          select <= select + 1'b1;
          if (select == SEL_WIDTH'(N_SYN - 1)) begin
            state_q <= FIRE;
            flush_q <= 1'b1;   // registered so it lines up with FIRE
          end
        end
        FIRE: begin
          spike   <= fire;
          toggle  <= ~toggle;
          state_q <= write ? LOAD : IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synaptic_input_processor.sv
// ---------------------------------------------------------------------------
// tb_synaptic_input_processor
// Table of windows {spikes, Ein, expected exc/inh sums, V, spike}; each
// driven window pushes its record to a scoreboard queue that is popped when
// the DUT raises its flush strobes. Hand sequences cover write dropping
// mid-window, all-zero windows with clamping, and reset mid-window.
// ---------------------------------------------------------------------------
module tb_synaptic_input_processor;
  import sip_pkg::*;

  typedef struct {
    logic [15:0] spikes;
    logic [15:0] ein;
    logic [7:0]  exc;
    logic [7:0]  inh;
    logic [11:0] v;
    logic        fire;
  } vec_t;

  localparam int NV = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic        write;
  logic [15:0] parallel_spike_in;
  logic [15:0] parallel_Ein;
  logic        flush_weight;
  logic        flush_Ein;
  logic        flush_spike;
  logic        spike;
  logic [3:0]  select;
  logic        toggle;

  vec_t vecs [NV];
  vec_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic exp_toggle = 1'b0;

  synaptic_input_processor dut (
    .clock             (clock),
    .reset             (reset),
    .write             (write),
    .parallel_spike_in (parallel_spike_in),
    .parallel_Ein      (parallel_Ein),
    .flush_weight      (flush_weight),
    .flush_Ein         (flush_Ein),
    .flush_spike       (flush_spike),
    .spike             (spike),
    .select            (select),
    .toggle            (toggle)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    parallel_spike_in = v.spikes;
    parallel_Ein      = v.ein;
    sb_q.push_back(v);
  endtask

  task automatic scramble();
    parallel_spike_in = 16'($urandom);
    parallel_Ein      = 16'($urandom);
  endtask

  // Waits (bounded) for the FIRE cycle, pops the expected window and checks
  // the accumulated sums, all three strobes and the window period.
  task automatic service_window(input string tag, input int start, output vec_t e, output int fcyc);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      if (flush_weight) seen = 1'b1;
    end
    check({tag, " flush seen"}, 32'(seen), 32'd1);
    fcyc = cyc;
    check({tag, " period"}, 32'(cyc - start), 32'd18);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, expected a record", tag);
      e = '{default: '0};
    end else begin
      e = sb_q.pop_front();
    end
    check({tag, " exc_acc"},     32'(dut.exc_acc), 32'(e.exc));
    check({tag, " inh_acc"},     32'(dut.inh_acc), 32'(e.inh));
    check({tag, " flush_Ein"},   32'(flush_Ein),   32'd1);
    check({tag, " flush_spike"}, 32'(flush_spike), 32'd1);
  endtask

  // Cycle after FIRE: spike pulse, new potential, toggle flip, strobes low.
  task automatic check_after(input string tag, input vec_t e);
    exp_toggle = ~exp_toggle;
    check({tag, " spike"},  32'(spike),              32'(e.fire));
    check({tag, " V"},      32'(dut.u_lif.v_q),      32'(e.v));
    check({tag, " toggle"}, 32'(toggle),             32'(exp_toggle));
    check({tag, " flush"},  32'(flush_weight),       32'd0);
  endtask

  initial begin
    vec_t e;
    int   start;
    int   pulses;
    bit   found;

    reset = 1'b1;
    write = 1'b0;
    parallel_spike_in = '0;
    parallel_Ein      = '0;

    //            spikes    Ein       exc    inh    V        fire
    vecs[0]  = '{16'hAAAA, 16'hFFFF, 8'd64, 8'd0,   12'd63,  1'b0};
    vecs[1]  = '{16'hAAAA, 16'hFFFF, 8'd64, 8'd0,   12'd0,   1'b1};
    vecs[2]  = '{16'hAAAA, 16'hFFFF, 8'd64, 8'd0,   12'd63,  1'b0};
    vecs[3]  = '{16'hD55D, 16'hAAAA, 8'd18, 8'd56,  12'd24,  1'b0};
    vecs[4]  = '{16'hFFFF, 16'h0000, 8'd0,  8'd120, 12'd0,   1'b0};
    vecs[5]  = '{16'h0000, 16'h5A5A, 8'd0,  8'd0,   12'd0,   1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 8'd120,8'd0,   12'd0,   1'b1};
    vecs[7]  = '{16'h8001, 16'h8000, 8'd15, 8'd0,   12'd14,  1'b0};
    vecs[8]  = '{16'h0010, 16'h0010, 8'd4,  8'd0,   12'd17,  1'b0};
    vecs[9]  = '{16'h0020, 16'h0000, 8'd0,  8'd5,   12'd11,  1'b0};
    vecs[10] = '{16'h00F0, 16'h00F0, 8'd22, 8'd0,   12'd32,  1'b0};
    vecs[11] = '{16'hFF00, 16'hFF00, 8'd92, 8'd0,   12'd0,   1'b1};

    #5 reset = 1'b0;

    // Reset state, idling with write low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("rst spike",  32'(spike),        32'd0);
      check("rst flush",  32'(flush_weight | flush_Ein | flush_spike), 32'd0);
      check("rst select", 32'(select),       32'd0);
      check("rst toggle", 32'(toggle),       32'd0);
      check("rst state",  32'(dut.state_q),  32'(IDLE));
      check("rst V",      32'(dut.u_lif.v_q), 32'd0);
    end

    // Table-driven back-to-back windows under continuous write.
    @(negedge clock);
    drive(vecs[0]);
    write = 1'b1;
    start = cyc;
    for (int i = 0; i < NV; i++) begin
      service_window($sformatf("vec%0d", i), start, e, start);
      if (i < NV - 1) drive(vecs[i + 1]);
      else            write = 1'b0;
      @(negedge clock);
      check_after($sformatf("vec%0d", i), e);
      if (i < NV - 1) begin
        @(negedge clock);
        check($sformatf("vec%0d spike width", i), 32'(spike), 32'd0);
        scramble();   // must not disturb the window already captured
      end
    end
    check("table end state", 32'(dut.state_q), 32'(IDLE));

    // write drops mid-window: window completes, then IDLE.
    @(negedge clock);
    drive('{16'h0004, 16'h0004, 8'd2, 8'd0, 12'd1, 1'b0});
    write = 1'b1;
    start = cyc;
    repeat (5) @(negedge clock);
    write = 1'b0;
    scramble();
    service_window("wr_drop", start, e, start);
    @(negedge clock);
    check_after("wr_drop", e);
    check("wr_drop state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clock);
    check("wr_drop stays idle", 32'(dut.state_q), 32'(IDLE));
    check("wr_drop select",     32'(select),      32'd0);

    // All-zero windows: 1 -> 0, then clamped at 0; then a small excitation.
    @(negedge clock);
    drive('{16'h0000, 16'hFFFF, 8'd0, 8'd0, 12'd0, 1'b0});
    write = 1'b1;
    start = cyc;
    service_window("zero0", start, e, start);
    drive('{16'h0000, 16'h0000, 8'd0, 8'd0, 12'd0, 1'b0});
    @(negedge clock);
    check_after("zero0", e);
    service_window("zero1", start, e, start);
    drive('{16'h0008, 16'h0008, 8'd3, 8'd0, 12'd2, 1'b0});
    @(negedge clock);
    check_after("zero1", e);
    service_window("small", start, e, start);
    // Next window would fire, but gets aborted by reset.
    parallel_spike_in = 16'hFFFF;
    parallel_Ein      = 16'hFFFF;
    @(negedge clock);
    check_after("small", e);

    // Reset asserted at select = 7 mid-window.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (dut.state_q == ACCUM && select == 4'd7) found = 1'b1;
    end
    check("mid rst reach select7", 32'(found), 32'd1);
    reset = 1'b1;
    write = 1'b0;
    #1;
    check("mid rst select",  32'(select),          32'd0);
    check("mid rst toggle",  32'(toggle),          32'd0);
    check("mid rst spike",   32'(spike),           32'd0);
    check("mid rst flush",   32'(flush_weight),    32'd0);
    check("mid rst state",   32'(dut.state_q),     32'(IDLE));
    check("mid rst exc",     32'(dut.exc_acc),     32'd0);
    check("mid rst spk_q",   32'(dut.spk_q),       32'd0);
    check("mid rst V",       32'(dut.u_lif.v_q),   32'd0);
    exp_toggle = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clock);
      if (flush_weight || flush_Ein || flush_spike || spike) pulses++;
    end
    check("post rst no pulses", 32'(pulses), 32'd0);
    check("post rst state",     32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
